// File: rtl/instr_mem_sync_if.sv
// Fetch and program-load signal bundle for instr_mem_sync.
// The master drives requests and load data; the slave (memory) returns fetch results and status.
interface instr_mem_sync_if #(
  parameter int unsigned DATA_W = 32
);
  logic [31:0]       Address;
  logic              ReadEn;
  logic              Stall;
  logic [DATA_W-1:0] Instruction;
  logic              InstrValid;
  logic              Fault;
  logic              LoadStart;
  logic [31:0]       LoadBase;
  logic [15:0]       LoadCount;
  logic              LoadValid;
  logic [DATA_W-1:0] LoadData;
  logic              LoadReady;
  logic              Busy;
  logic              LoadErr;

  modport master (
    output Address, ReadEn, Stall, LoadStart, LoadBase, LoadCount, LoadValid, LoadData,
    input  Instruction, InstrValid, Fault, LoadReady, Busy, LoadErr
  );

  modport slave (
    input  Address, ReadEn, Stall, LoadStart, LoadBase, LoadCount, LoadValid, LoadData,
    output Instruction, InstrValid, Fault, LoadReady, Busy, LoadErr
  );
endinterface

// File: rtl/instr_mem_sync.sv
// Instruction memory with one-cycle registered fetch and a streaming program loader.
// Memory contents are never reset; a reset only aborts an in-flight load.
module instr_mem_sync #(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       DEPTH    = 256,
  parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
  input logic                 Clk,
  input logic                 Reset,
  instr_mem_sync_if.slave     mem_if
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = 31;

  typedef enum logic [0:0] {StIdle, StLoad} state_e;

  state_e            state_q, state_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [15:0]       rem_q, rem_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic              valid_q, valid_d;
  logic              fault_q, fault_d;
  logic              mem_we;
  logic              busy;
  logic              addr_fault;
  logic [DATA_W-1:0] rd_word;

  logic [DATA_W-1:0] mem_q [DEPTH];

  assign busy       = (state_q == StLoad);
  assign addr_fault = (mem_if.Address[1:0] != 2'b00) ||
                      (mem_if.Address[31:IDX_W+2] != '0);
  assign rd_word    = mem_q[mem_if.Address[IDX_W+1:2]];

  // Load FSM
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    err_d   = err_q;
    mem_we  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (mem_if.LoadStart) begin
          if (mem_if.LoadBase[1:0] != 2'b00) begin
            err_d = 1'b1;
          end else if (mem_if.LoadCount != 16'd0) begin
            state_d = StLoad;
            ptr_d   = {1'b0, mem_if.LoadBase[31:2]};
            rem_d   = mem_if.LoadCount;
            err_d   = 1'b0;
          end
        end
      end
      StLoad: begin
        if (mem_if.LoadValid) begin
          // Out-of-range words are dropped, but still count toward the load length.
          if (ptr_q < PTR_W'(DEPTH)) begin
            mem_we = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          ptr_d = ptr_q + PTR_W'(1);
          rem_d = rem_q - 16'd1;
          if (rem_q == 16'd1) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Fetch path: stall holds everything, a busy loader refuses fetches.
  always_comb begin
    instr_d = instr_q;
    valid_d = valid_q;
    fault_d = fault_q;
    if (!mem_if.Stall) begin
      if (mem_if.ReadEn && !busy) begin
        valid_d = 1'b1;
        fault_d = addr_fault;
        instr_d = addr_fault ? NOP_WORD : rd_word;
      end else begin
        valid_d = 1'b0;
        fault_d = 1'b0;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      rem_q   <= '0;
      err_q   <= 1'b0;
      instr_q <= NOP_WORD;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset && mem_we) begin
      mem_q[ptr_q[IDX_W-1:0]] <= mem_if.LoadData;
    end
  end

  assign mem_if.Instruction = instr_q;
  assign mem_if.InstrValid  = valid_q;
  assign mem_if.Fault       = fault_q;
  assign mem_if.Busy        = busy;
  assign mem_if.LoadReady   = busy;
  assign mem_if.LoadErr     = err_q;

endmodule

// File: tb/tb_instr_mem_sync.sv
// Directed bench for instr_mem_sync: loads, fetches, faults, stalls and reset behaviour.
module tb_instr_mem_sync;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned DEPTH    = 256;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic Clk;
  logic Reset;
  int   n_cmp;
  int   n_err;

  instr_mem_sync_if #(.DATA_W(DATA_W)) bus ();

  instr_mem_sync #(
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .NOP_WORD(NOP)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .mem_if(bus.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.Address   = '0;
    bus.ReadEn    = 1'b0;
    bus.Stall     = 1'b0;
    bus.LoadStart = 1'b0;
    bus.LoadBase  = '0;
    bus.LoadCount = '0;
    bus.LoadValid = 1'b0;
    bus.LoadData  = '0;
  endtask

  task automatic test_reset();
    // Reset must win over every concurrent request.
    Reset         = 1'b1;
    bus.ReadEn    = 1'b1;
    bus.LoadStart = 1'b1;
    bus.LoadCount = 16'd1;
    bus.LoadValid = 1'b1;
    tick();
    n_cmp++;
    if (bus.Instruction !== NOP || bus.InstrValid !== 1'b0 || bus.Fault !== 1'b0) begin
      $display("FAIL reset_fetch: instr=%h valid=%b fault=%b, want %h 0 0",
               bus.Instruction, bus.InstrValid, bus.Fault, NOP);
      n_err++;
    end
    n_cmp++;
    if (bus.Busy !== 1'b0 || bus.LoadReady !== 1'b0 || bus.LoadErr !== 1'b0) begin
      $display("FAIL reset_load: busy=%b ready=%b err=%b, want 0 0 0",
               bus.Busy, bus.LoadReady, bus.LoadErr);
      n_err++;
    end
    Reset = 1'b0;
    idle_inputs();
    tick();
    n_cmp++;
    if (bus.Busy !== 1'b0) begin
      $display("FAIL reset_no_load: busy=%b, want 0", bus.Busy);
      n_err++;
    end
  endtask

  task automatic test_load_basic();
    logic [31:0] data [4];
    logic        vld  [4];
    logic [31:0] exp  [3];
    int          busy_cycles;
    data = '{32'hA, 32'h0, 32'hB, 32'hC};
    vld  = '{1'b1, 1'b0, 1'b1, 1'b1};
    exp  = '{32'hA, 32'hB, 32'hC};
    bus.LoadStart = 1'b1;
    bus.LoadBase  = 32'h0;
    bus.LoadCount = 16'd3;
    tick();
    bus.LoadStart = 1'b0;
    busy_cycles = bus.Busy ? 1 : 0;
    for (int i = 0; i < 4; i++) begin
      bus.LoadValid = vld[i];
      bus.LoadData  = data[i];
      tick();
      if (i == 1) begin
        n_cmp++;
        if (bus.LoadReady !== 1'b1) begin
          $display("FAIL load_ready_bubble: ready=%b, want 1", bus.LoadReady);
          n_err++;
        end
      end
      if (bus.Busy) busy_cycles++;
    end
    bus.LoadValid = 1'b0;
    n_cmp++;
    if (busy_cycles != 4 || bus.Busy !== 1'b0 || bus.LoadErr !== 1'b0) begin
      $display("FAIL load_busy_len: cycles=%0d busy=%b err=%b, want 4 0 0",
               busy_cycles, bus.Busy, bus.LoadErr);
      n_err++;
    end
    bus.ReadEn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.Address = 32'(i * 4);
      tick();
      n_cmp++;
      if (bus.Instruction !== exp[i] || bus.InstrValid !== 1'b1 || bus.Fault !== 1'b0) begin
        $display("FAIL fetch_loaded[%0d]: instr=%h valid=%b fault=%b, want %h 1 0",
                 i, bus.Instruction, bus.InstrValid, bus.Fault, exp[i]);
        n_err++;
      end
    end
  endtask

  task automatic test_stall();
    bus.ReadEn  = 1'b1;
    bus.Address = 32'h4;
    tick();
    bus.Stall   = 1'b1;
    bus.Address = 32'h8;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (bus.Instruction !== 32'hB || bus.InstrValid !== 1'b1) begin
        $display("FAIL stall_hold[%0d]: instr=%h valid=%b, want 0000000b 1",
                 i, bus.Instruction, bus.InstrValid);
        n_err++;
      end
    end
    bus.Stall = 1'b0;
    tick();
    n_cmp++;
    if (bus.Instruction !== 32'hC || bus.InstrValid !== 1'b1) begin
      $display("FAIL stall_release: instr=%h valid=%b, want 0000000c 1",
               bus.Instruction, bus.InstrValid);
      n_err++;
    end
  endtask

  task automatic test_no_read();
    bus.ReadEn = 1'b0;
    tick();
    n_cmp++;
    if (bus.Instruction !== 32'hC || bus.InstrValid !== 1'b0 || bus.Fault !== 1'b0) begin
      $display("FAIL no_read: instr=%h valid=%b fault=%b, want 0000000c 0 0",
               bus.Instruction, bus.InstrValid, bus.Fault);
      n_err++;
    end
  endtask

  task automatic test_fault();
    logic [31:0] addrs [3];
    addrs = '{32'h6, 32'h400, 32'h8000_0000};
    bus.ReadEn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.Address = addrs[i];
      tick();
      n_cmp++;
      if (bus.Instruction !== NOP || bus.InstrValid !== 1'b1 || bus.Fault !== 1'b1) begin
        $display("FAIL fetch_fault[%h]: instr=%h valid=%b fault=%b, want %h 1 1",
                 addrs[i], bus.Instruction, bus.InstrValid, bus.Fault, NOP);
        n_err++;
      end
    end
    bus.ReadEn = 1'b0;
    bus.Stall  = 1'b1;
    tick();
    n_cmp++;
    if (bus.Fault !== 1'b1 || bus.InstrValid !== 1'b1) begin
      $display("FAIL stall_fault_hold: fault=%b valid=%b, want 1 1", bus.Fault, bus.InstrValid);
      n_err++;
    end
    bus.Stall = 1'b0;
  endtask

  task automatic test_overflow_load();
    bus.LoadStart = 1'b1;
    bus.LoadBase  = 32'h3F8;
    bus.LoadCount = 16'd4;
    tick();
    bus.LoadStart = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.LoadValid = 1'b1;
      bus.LoadData  = 32'h1000 + 32'(i);
      // A restart mid-load must be ignored.
      bus.LoadStart = (i == 1);
      bus.LoadBase  = 32'h0;
      bus.LoadCount = 16'd1;
      tick();
      if (i == 2) begin
        n_cmp++;
        if (bus.Busy !== 1'b1 || bus.LoadErr !== 1'b1) begin
          $display("FAIL ovf_mid: busy=%b err=%b, want 1 1", bus.Busy, bus.LoadErr);
          n_err++;
        end
      end
    end
    bus.LoadStart = 1'b0;
    bus.LoadValid = 1'b0;
    n_cmp++;
    if (bus.Busy !== 1'b0 || bus.LoadErr !== 1'b1) begin
      $display("FAIL ovf_end: busy=%b err=%b, want 0 1", bus.Busy, bus.LoadErr);
      n_err++;
    end
    bus.ReadEn  = 1'b1;
    bus.Address = 32'h3F8;
    tick();
    n_cmp++;
    if (bus.Instruction !== 32'h1000 || bus.Fault !== 1'b0) begin
      $display("FAIL ovf_word254: instr=%h fault=%b, want 00001000 0", bus.Instruction, bus.Fault);
      n_err++;
    end
    bus.Address = 32'h3FC;
    tick();
    n_cmp++;
    if (bus.Instruction !== 32'h1001 || bus.Fault !== 1'b0) begin
      $display("FAIL ovf_word255: instr=%h fault=%b, want 00001001 0", bus.Instruction, bus.Fault);
      n_err++;
    end
    bus.Address = 32'h0;
    tick();
    n_cmp++;
    if (bus.Instruction !== 32'hA || bus.LoadErr !== 1'b1) begin
      $display("FAIL ovf_no_wrap: instr=%h err=%b, want 0000000a 1", bus.Instruction, bus.LoadErr);
      n_err++;
    end
    bus.ReadEn = 1'b0;
  endtask

  task automatic test_busy_fetch();
    bus.LoadStart = 1'b1;
    bus.LoadBase  = 32'h10;
    bus.LoadCount = 16'd1;
    tick();
    bus.LoadStart = 1'b0;
    n_cmp++;
    if (bus.Busy !== 1'b1 || bus.LoadErr !== 1'b0) begin
      $display("FAIL start_clears_err: busy=%b err=%b, want 1 0", bus.Busy, bus.LoadErr);
      n_err++;
    end
    bus.ReadEn  = 1'b1;
    bus.Address = 32'h0;
    tick();
    n_cmp++;
    if (bus.InstrValid !== 1'b0 || bus.Fault !== 1'b0 || bus.Busy !== 1'b1) begin
      $display("FAIL busy_fetch: valid=%b fault=%b busy=%b, want 0 0 1",
               bus.InstrValid, bus.Fault, bus.Busy);
      n_err++;
    end
    bus.ReadEn    = 1'b0;
    bus.LoadValid = 1'b1;
    bus.LoadData  = 32'h55;
    tick();
    bus.LoadValid = 1'b0;
    n_cmp++;
    if (bus.Busy !== 1'b0 || bus.LoadReady !== 1'b0) begin
      $display("FAIL single_load_end: busy=%b ready=%b, want 0 0", bus.Busy, bus.LoadReady);
      n_err++;
    end
    bus.LoadStart = 1'b1;
    bus.LoadBase  = 32'h2;
    bus.LoadCount = 16'd1;
    tick();
    n_cmp++;
    if (bus.Busy !== 1'b0 || bus.LoadErr !== 1'b1) begin
      $display("FAIL misaligned_start: busy=%b err=%b, want 0 1", bus.Busy, bus.LoadErr);
      n_err++;
    end
    bus.LoadBase  = 32'h40;
    bus.LoadCount = 16'd0;
    tick();
    bus.LoadStart = 1'b0;
    n_cmp++;
    if (bus.Busy !== 1'b0 || bus.LoadErr !== 1'b1) begin
      $display("FAIL zero_count: busy=%b err=%b, want 0 1", bus.Busy, bus.LoadErr);
      n_err++;
    end
    bus.ReadEn  = 1'b1;
    bus.Address = 32'h10;
    tick();
    bus.ReadEn  = 1'b0;
    n_cmp++;
    if (bus.Instruction !== 32'h55 || bus.InstrValid !== 1'b1) begin
      $display("FAIL read_after_load: instr=%h valid=%b, want 00000055 1",
               bus.Instruction, bus.InstrValid);
      n_err++;
    end
  endtask

  task automatic test_reset_mid_load();
    bus.LoadStart = 1'b1;
    bus.LoadBase  = 32'h20;
    bus.LoadCount = 16'd3;
    tick();
    bus.LoadStart = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.LoadValid = 1'b1;
      bus.LoadData  = 32'h300 + 32'(i);
      tick();
    end
    bus.LoadStart = 1'b1;
    bus.LoadCount = 16'd5;
    bus.LoadValid = 1'b0;
    tick();
    bus.LoadStart = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.LoadValid = 1'b1;
      bus.LoadData  = 32'h200 + 32'(i);
      tick();
    end
    Reset        = 1'b1;
    bus.LoadData = 32'h202;
    tick();
    Reset         = 1'b0;
    bus.LoadValid = 1'b0;
    n_cmp++;
    if (bus.Busy !== 1'b0 || bus.LoadReady !== 1'b0 || bus.LoadErr !== 1'b0) begin
      $display("FAIL reset_abort: busy=%b ready=%b err=%b, want 0 0 0",
               bus.Busy, bus.LoadReady, bus.LoadErr);
      n_err++;
    end
    bus.ReadEn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      logic [31:0] exp;
      exp = (i < 2) ? 32'h200 + 32'(i) : 32'h302;
      bus.Address = 32'h20 + 32'(i * 4);
      tick();
      n_cmp++;
      if (bus.Instruction !== exp || bus.InstrValid !== 1'b1) begin
        $display("FAIL reset_keep[%0d]: instr=%h valid=%b, want %h 1",
                 i, bus.Instruction, bus.InstrValid, exp);
        n_err++;
      end
    end
    bus.ReadEn = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    Reset = 1'b0;
    idle_inputs();
    test_reset();
    test_load_basic();
    test_stall();
    test_no_read();
    test_fault();
    test_overflow_load();
    test_busy_fetch();
    test_reset_mid_load();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/instr_mem_sync.md
INSTR_MEM_SYNC -- requirements
Module: instr_mem_sync

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning instruction word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 256, meaning number of words, power of two, 2..4096.
REQ-003 The block SHALL have parameter NOP_WORD, default 0, meaning word driven on faulted reads.
REQ-004 The block SHALL derive local IDX_W = log2(DEPTH) and use word index Address[IDX_W+1:2].
REQ-005 The block SHALL have these ports, one clock, synchronous active-high reset:
- Clk  in  1  rising-edge clock
- Reset  in  1  synchronous active-high reset
- Address  in  32  byte address of the fetch
- ReadEn  in  1  fetch request this cycle
- Stall  in  1  hold current outputs
- Instruction  out  DATA_W  registered fetched word
- InstrValid  out  1  Instruction holds a fresh fetch result
- Fault  out  1  last fetch was misaligned or out of range
- LoadStart  in  1  one-cycle pulse starting a program load
- LoadBase  in  32  byte start address, sampled on LoadStart
- LoadCount  in  16  words to load, sampled on LoadStart
- LoadValid  in  1  LoadData valid this cycle
- LoadData  in  DATA_W  word to write
- LoadReady  out  1  block accepts LoadData this cycle
- Busy  out  1  load in progress, fetches refused
- LoadErr  out  1  sticky: load hit misaligned base or range overflow

Function
REQ-006 Read latency SHALL be one cycle: ReadEn=1, Stall=0, Busy=0 at edge N -> Instruction/InstrValid/Fault valid after edge N.
REQ-007 A fetch with Address[1:0]!=0 or Address[31:IDX_W+2]!=0 SHALL return NOP_WORD with Fault=1, InstrValid=1.
REQ-008 A fetch with ReadEn=0, Stall=0 SHALL clear InstrValid and Fault; Instruction holds its previous value.
REQ-009 Stall=1 SHALL hold Instruction, InstrValid and Fault unchanged, overriding ReadEn.
REQ-010 ReadEn while Busy=1 SHALL be ignored: InstrValid=0, Fault=0 next cycle.
REQ-011 Load FSM states SHALL be IDLE and LOAD.
REQ-012 IDLE->LOAD on LoadStart=1 with LoadCount!=0 and LoadBase[1:0]==0; pointer <= LoadBase index, remaining <= LoadCount.
REQ-013 LoadStart with LoadCount==0 SHALL stay IDLE with no effect; with LoadBase[1:0]!=0 SHALL stay IDLE and set LoadErr.
REQ-014 In LOAD, LoadReady=1 and Busy=1; each cycle with LoadValid=1 writes LoadData to memory[pointer], increments pointer, decrements remaining.
REQ-015 Writes whose pointer >= DEPTH SHALL be discarded, set LoadErr, and still decrement remaining (no wrap).
REQ-016 LOAD->IDLE on the edge that consumes the last word; Busy and LoadReady fall after that edge.
REQ-017 LoadStart while in LOAD SHALL be ignored.
REQ-018 LoadValid=0 cycles in LOAD SHALL stall the load indefinitely without timeout.
REQ-019 LoadErr SHALL clear only on Reset or on an accepted LoadStart (REQ-012).
REQ-020 A written word SHALL be readable by a fetch issued the cycle after Busy falls.
REQ-021 In IDLE, LoadReady=0 and LoadValid SHALL be ignored.

Reset
REQ-022 Reset=1 at an edge SHALL set Instruction=NOP_WORD, InstrValid=0, Fault=0, LoadErr=0, Busy=0, LoadReady=0, FSM=IDLE.
REQ-023 Reset SHALL NOT alter memory contents; Reset mid-LOAD aborts the load, keeping words already written.
REQ-024 Reset SHALL take priority over Stall, ReadEn, LoadStart and LoadValid in the same cycle.

Verification
REQ-025 Load base 0x0, count 3, words 0xA,0xB,0xC with one LoadValid=0 bubble -> Busy high 4 cycles; fetches 0x0,0x4,0x8 return 0xA,0xB,0xC, InstrValid=1, Fault=0.
REQ-026 Fetch 0x6 -> Instruction=NOP_WORD, Fault=1, InstrValid=1; fetch 0x400 with DEPTH=256 -> Fault=1.
REQ-027 Fetch 0x4 then Stall=1 for 3 cycles while Address=0x8 -> Instruction stays 0xB; after Stall=0, 0xC one cycle later.
REQ-028 Load base 0x3F8, count 4, DEPTH=256 -> words 254,255 written, 2 discarded, LoadErr=1, Busy falls after 4th word.
REQ-029 ReadEn=1 during LOAD -> InstrValid=0; LoadStart with base 0x2 -> FSM stays IDLE, LoadErr=1.
REQ-030 Reset after 2 of 5 load words -> Busy=0, LoadErr=0 next cycle; words 0,1 readable, word 2 unchanged.
